lfsr_8bit: RTL and testbench
============================

// Module: lfsr_8bit
// PURPOSE
//   Free-running 8-bit pseudo-random sequence generator (shift-left LFSR, Fibonacci form).
//   Loads a fixed non-zero seed on reset, then advances one state per clock with no enable.
//   Used as a cheap test-pattern / scrambler source; data is the raw register contents.
// PARAMETERS
//   WIDTH  8      state/output width; the behaviour below is specified for 8 only
//   SEED   8'h8A  value loaded on reset; must have SEED[6:0] != 0
//   TAPS   8'h69  feedback mask: bits 6,5,3,0 of the current state are XORed
// PORTS
//   clk      input   1      single clock; all state updates on its rising edge
//   reset    input   1      synchronous, active-high reset
//   data     output  8      current LFSR state, driven directly from the state register
// BEHAVIOUR
//   - One clock domain. Reset is synchronous and active-high. Both are fixed.
//   - Reset: at any rising clk edge where reset=1, state <= SEED (8'h8A).
//     Reset has priority over the shift. A reset mid-sequence restarts from SEED on that edge.
//     No reset value is defined before the first clock edge that samples reset=1.
//   - Run: at each rising clk edge where reset=0:
//       fb    = ^(state & TAPS) = state[6]^state[5]^state[3]^state[0]
//       state <= {state[6:0], fb}
//   - Output: data = state, registered, with no combinational path from inputs.
//     In the first cycle after reset is deasserted, data = SEED.
//     Each following edge advances data by one step, so latency is 1 clock per step.
//   - Sequence start: 8A, 15, 2B, 57, AE, 5C, ...
//   - Bit 7 does not feed back. state[6:0] is a 7-bit LFSR with polynomial
//     x^7+x^6+x^3+x+1, which is primitive, so its period is 127.
//   - Bit 7 is state[6] delayed by one cycle.
//   - For n>=1, data(n+127) == data(n).
//   - data is never 8'h00 while SEED[6:0] != 0, so there is no lock-up state.
//     No lock-up escape logic is required.
//   - Illegal-seed handling: none. A SEED with SEED[6:0]==0 yields all-zero after one step.
//     Such a seed is a configuration error.
//   - No X-propagation tolerance is required beyond reset.
//     The bench must apply reset before checking data.
// STRUCTURE
//   - Shared package (lfsr_pkg): LFSR_WIDTH=8, LFSR_SEED=8'h8A, LFSR_TAPS=8'h69.
//     The package also holds a function lfsr_next(state) returning {state[6:0], ^(state&TAPS)}.
//     Testbench models reuse this function.
//   - No sub-module. The design is one state register plus an XOR reduction.
//   - The bench should carry a scoreboard built from lfsr_next.
// TESTING
//   1. Reset held 2 cycles, then released:
//      data == 8'h8A in the first post-release cycle,
//      then 8'h15, 8'h2B, 8'h57, 8'hAE, 8'h5C on successive edges.
//   2. Free run 256 cycles after reset:
//      every data value matches the reference model lfsr_next applied iteratively from 8'h8A;
//      data is never 8'h00.
//   3. Period check:
//      data at step 128 == data at step 1 == 8'h15;
//      no earlier repeat of the step-1 value occurs.
//      data[6:0] at step 127 == 7'h0A.
//   4. Mid-run reset: run 50 steps, assert reset for 1 cycle at an arbitrary edge.
//      data == 8'h8A on the next cycle, and the sequence 8'h15, 8'h2B, ... follows.
//   5. Reset held for 10 cycles: data stays 8'h8A on every cycle while reset=1.
//      data advances only after deassertion.
//   6. Back-to-back reset pulses (1 cycle on, 1 cycle off, repeated):
//      data alternates 8'h8A, 8'h15, 8'h8A, 8'h15.

Source files
------------

// File: rtl/lfsr_pkg.sv
// lfsr_pkg: shared LFSR constants and the one-step next-state function
package lfsr_pkg;
  localparam int LFSR_WIDTH = 8;
  localparam logic [LFSR_WIDTH-1:0] LFSR_SEED = 8'h8A;
  localparam logic [LFSR_WIDTH-1:0] LFSR_TAPS = 8'h69;
  function automatic logic [LFSR_WIDTH-1:0] lfsr_next(input logic [LFSR_WIDTH-1:0] s);
    return {s[LFSR_WIDTH-2:0], ^(s & LFSR_TAPS)};
  endfunction
endpackage

// File: rtl/lfsr_8bit.sv
// lfsr_8bit: free-running 8-bit Fibonacci LFSR, seed loaded on synchronous reset
module lfsr_8bit
  import lfsr_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  output logic [LFSR_WIDTH-1:0] data
);
  logic [LFSR_WIDTH-1:0] r_state;
  // reload the seed on reset, otherwise advance one LFSR step per clock
  always_ff @(posedge clk)
    r_state <= reset ? LFSR_SEED : lfsr_next(r_state);
  assign data = r_state;
endmodule

// File: tb/tb_lfsr_8bit.sv
// tb_lfsr_8bit: scoreboard and directed/random reset checks for lfsr_8bit
module tb_lfsr_8bit;
  import lfsr_pkg::*;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] data;
  logic [7:0] m_state = '0;
  logic       m_valid = 1'b0;
  logic [7:0] hist [0:256];
  int ncmp = 0;
  int nerr = 0;

  lfsr_8bit dut (.clk(clk), .reset(reset), .data(data));

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    ncmp++;
    if (a !== e) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask

  // reference model: seed on reset, otherwise one lfsr_next step per edge
  always @(posedge clk) begin
    if (reset) begin
      m_state <= LFSR_SEED;
      m_valid <= 1'b1;
    end else m_state <= lfsr_next(m_state);
  end

  // compare every cycle once the model has seen a reset
  always @(negedge clk) begin
    if (m_valid) begin
      chk("model", {24'd0, data}, {24'd0, m_state});
      chk("nonzero", {31'd0, data == 8'h00}, 32'd0);
    end
  end

  logic [7:0] exp_seq [0:5] = '{8'h8A, 8'h15, 8'h2B, 8'h57, 8'hAE, 8'h5C};

  initial begin
    int first_rep;
    logic [7:0] e;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    for (int k = 0; k <= 256; k++) begin
      @(negedge clk);
      hist[k] = data;
      if (k <= 5) begin
        e = exp_seq[k];
        chk($sformatf("start_%0d", k), {24'd0, data}, {24'd0, e});
      end
    end
    chk("step1", {24'd0, hist[1]}, 32'h15);
    chk("step128", {24'd0, hist[128]}, 32'h15);
    chk("step127_low7", {25'd0, hist[127][6:0]}, 32'h0A);
    first_rep = -1;
    for (int k = 2; k <= 256; k++)
      if (first_rep < 0 && hist[k] == hist[1]) first_rep = k;
    chk("first_repeat", first_rep, 128);
    repeat ($urandom_range(0, 20)) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midrst_seed", {24'd0, data}, 32'h8A);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      e = exp_seq[k];
      chk("midrst_seq", {24'd0, data}, {24'd0, e});
    end
    reset = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("held_rst", {24'd0, data}, 32'h8A);
    end
    reset = 1'b0;
    @(negedge clk);
    chk("held_release", {24'd0, data}, 32'h15);
    for (int k = 0; k < 4; k++) begin
      reset = 1'b1;
      @(negedge clk);
      chk("pulse_on", {24'd0, data}, 32'h8A);
      reset = 1'b0;
      @(negedge clk);
      chk("pulse_off", {24'd0, data}, 32'h15);
    end
    for (int k = 0; k < 400; k++) begin
      reset = ($urandom_range(0, 15) == 0);
      @(negedge clk);
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
